fifo_request_arbiter: RTL and testbench

- Shares the write port of one fifo_queue instance among NUM_REQUESTER requesters, using round-robin arbitration.
- Upstream, each requester uses the same valid/ack handshake as the FIFO write port: hold valid and data until a one-cycle ack pulse arrives.
- Downstream, the block drives the FIFO request_in / request_valid_in, and takes the FIFO issue_ack_out as its issue_ack_in.
- Sits between per-core or per-bank request sources and a shared request queue.

---
 rtl/fifo_request_arbiter_pkg.sv | 20 ++
 rtl/fifo_request_arbiter_rr_priority_picker.sv | 51 +++++
 rtl/fifo_request_arbiter.sv | 101 ++++++++++
 tb/tb_fifo_request_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_request_arbiter_pkg.sv
// ============================================================================
// Module      : fifo_request_arbiter_pkg
// Description : Shared state encoding for the FIFO request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_request_arbiter_pkg;

    localparam int ARB_STATE_WIDTH_IN_BITS = 2;

    typedef enum logic [ARB_STATE_WIDTH_IN_BITS-1:0] {
        ARB_STATE_IDLE  = 2'd0,
        ARB_STATE_ISSUE = 2'd1,
        ARB_STATE_ACK   = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_request_arbiter_rr_priority_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker; search starts after last_winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int NUM_REQUESTER               = 4,
    parameter int REQUESTER_PTR_WIDTH_IN_BITS = 2
) (
    input  logic [NUM_REQUESTER-1:0]               eligible,
    input  logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0] last_winner,
    output logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0] winner,
    output logic                                   any_eligible
);

    localparam int DOUBLE_WIDTH = 2 * NUM_REQUESTER;
    localparam int POS_WIDTH    = REQUESTER_PTR_WIDTH_IN_BITS + 1;
    localparam logic [POS_WIDTH-1:0] NUM_EXT = POS_WIDTH'(NUM_REQUESTER);

    logic [DOUBLE_WIDTH-1:0] doubled;
    logic [DOUBLE_WIDTH-1:0] masked;
    logic [POS_WIDTH-1:0]    pos;

    // Bits at or below last_winner in the low copy are masked out, so the
    // lowest surviving bit is the next requester in rotation order and the
    // upper copy supplies the wrap-around, with last_winner itself checked last.
    always_comb begin
        doubled = {eligible, eligible};
        masked  = '0;
        for (int j = 0; j < DOUBLE_WIDTH; j++) begin
            masked[j] = doubled[j] & (j > int'(last_winner));
        end
        pos = '0;
        for (int j = DOUBLE_WIDTH - 1; j >= 0; j--) begin
            if (masked[j]) begin
                pos = POS_WIDTH'(j);
            end
        end
        if (pos >= NUM_EXT) begin
            winner = REQUESTER_PTR_WIDTH_IN_BITS'(pos - NUM_EXT);
        end else begin
            winner = REQUESTER_PTR_WIDTH_IN_BITS'(pos);
        end
        any_eligible = |eligible;
    end

endmodule

`default_nettype wire

// File: rtl/fifo_request_arbiter.sv
// ============================================================================
// Module      : fifo_request_arbiter
// Description : Round-robin sharing of one FIFO write port among N requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_request_arbiter
    import fifo_request_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTER               = 4,
    parameter int REQUESTER_PTR_WIDTH_IN_BITS = 2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS  = 64
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
    input  logic [NUM_REQUESTER-1:0]                            request_valid_packed_in,
    input  logic [NUM_REQUESTER-1:0]                            request_mask_in,
    output logic [NUM_REQUESTER-1:0]                            issue_ack_packed_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               request_out,
    output logic                                                request_valid_out,
    input  logic                                                issue_ack_in,
    output logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0]              grant_index_out,
    output logic                                                busy_out
);

    localparam logic [NUM_REQUESTER-1:0] ONE_HOT_BASE = {{(NUM_REQUESTER-1){1'b0}}, 1'b1};
    localparam logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0] LAST_INDEX =
        REQUESTER_PTR_WIDTH_IN_BITS'(NUM_REQUESTER - 1);

    arb_state_t                               state;
    logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0]   last_winner;
    logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0]   winner;
    logic                                     any_eligible;
    logic [NUM_REQUESTER-1:0]                 eligible;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]    winner_payload;

    assign eligible       = request_valid_packed_in & request_mask_in;
    assign winner_payload = request_packed_in[int'(winner)*SINGLE_ENTRY_WIDTH_IN_BITS +: SINGLE_ENTRY_WIDTH_IN_BITS];
    assign busy_out       = (state != ARB_STATE_IDLE);

    rr_priority_picker #(
        .NUM_REQUESTER               (NUM_REQUESTER),
        .REQUESTER_PTR_WIDTH_IN_BITS (REQUESTER_PTR_WIDTH_IN_BITS)
    ) u_picker (
        .eligible     (eligible),
        .last_winner  (last_winner),
        .winner       (winner),
        .any_eligible (any_eligible)
    );

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state                <= ARB_STATE_IDLE;
            request_out          <= '0;
            request_valid_out    <= 1'b0;
            issue_ack_packed_out <= '0;
            grant_index_out      <= '0;
            last_winner          <= LAST_INDEX;
        end else begin
            case (state)
                ARB_STATE_IDLE: begin
                    issue_ack_packed_out <= '0;
                    if (any_eligible) begin
                        grant_index_out   <= winner;
                        request_out       <= winner_payload;
                        request_valid_out <= 1'b1;
                        state             <= ARB_STATE_ISSUE;
                    end else begin
                        request_out       <= '0;
                        request_valid_out <= 1'b0;
                    end
                end
                // Grant is committed here: requester valid/mask are not consulted.
                ARB_STATE_ISSUE: begin
                    if (issue_ack_in) begin
                        request_valid_out    <= 1'b0;
                        request_out          <= '0;
                        issue_ack_packed_out <= ONE_HOT_BASE << grant_index_out;
                        last_winner          <= grant_index_out;
                        state                <= ARB_STATE_ACK;
                    end
                end
                ARB_STATE_ACK: begin
                    issue_ack_packed_out <= '0;
                    state                <= ARB_STATE_IDLE;
                end
                default: begin
                    issue_ack_packed_out <= '0;
                    request_valid_out    <= 1'b0;
                    request_out          <= '0;
                    state                <= ARB_STATE_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_request_arbiter.sv
// ============================================================================
// Module      : tb_fifo_request_arbiter
// Description : Self-checking bench for fifo_request_arbiter (4 x 64-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_request_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic [N*W-1:0] request_packed_in;
    logic [N-1:0]   valid;
    logic [N-1:0]   mask;
    logic [N-1:0]   issue_ack_packed_out;
    logic [W-1:0]   request_out;
    logic           request_valid_out;
    logic           ack_in;
    logic [1:0]     grant_index_out;
    logic           busy_out;
    logic [W-1:0]   data [N];

    int checks = 0;
    int errors = 0;
    int m_last;

    always #5 clk_in = ~clk_in;

    always_comb begin
        request_packed_in = '0;
        for (int i = 0; i < N; i++) request_packed_in[i*W +: W] = data[i];
    end

    fifo_request_arbiter #(
        .NUM_REQUESTER               (N),
        .REQUESTER_PTR_WIDTH_IN_BITS (2),
        .SINGLE_ENTRY_WIDTH_IN_BITS  (W)
    ) dut (
        .clk_in                  (clk_in),
        .reset_in                (reset_in),
        .request_packed_in       (request_packed_in),
        .request_valid_packed_in (valid),
        .request_mask_in         (mask),
        .issue_ack_packed_out    (issue_ack_packed_out),
        .request_out             (request_out),
        .request_valid_out       (request_valid_out),
        .issue_ack_in            (ack_in),
        .grant_index_out         (grant_index_out),
        .busy_out                (busy_out)
    );

    // Reference rule: first eligible index after last, wrapping, last checked last.
    function automatic int rr_pick(input logic [N-1:0] elig, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        reset_in = 1'b0;
        valid = '0;
        mask = '1;
        ack_in = 1'b0;
        for (int i = 0; i < N; i++) data[i] = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b1;
        m_last = N - 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy_out, request_valid_out, issue_ack_packed_out, grant_index_out} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b v=%b ack=%b g=%0d want all 0",
                     busy_out, request_valid_out, issue_ack_packed_out, grant_index_out);
        end
        checks++;
        if (request_out !== '0) begin
            errors++; $display("FAIL reset_data got %h want 0", request_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        data[2] = 64'hA5;
        valid = 4'b0100;
        step();
        checks++;
        if (request_valid_out !== 1'b1 || request_out !== 64'hA5 || grant_index_out !== 2'd2) begin
            errors++;
            $display("FAIL single_grant got v=%b d=%h g=%0d want v=1 d=a5 g=2",
                     request_valid_out, request_out, grant_index_out);
        end
        step();
        checks++;
        if (request_valid_out !== 1'b1 || issue_ack_packed_out !== 4'b0000) begin
            errors++;
            $display("FAIL single_wait got v=%b ack=%b want v=1 ack=0000", request_valid_out, issue_ack_packed_out);
        end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        checks++;
        if (issue_ack_packed_out !== 4'b0100 || request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got ack=%b v=%b want ack=0100 v=0", issue_ack_packed_out, request_valid_out);
        end
        valid = '0;
        step();
        checks++;
        if (issue_ack_packed_out !== 4'b0000 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_clear got ack=%b busy=%b want 0000/0", issue_ack_packed_out, busy_out);
        end
    endtask

    task automatic test_fairness();
        int n;
        int prev;
        int exp_g;
        do_reset();
        valid = '1;
        ack_in = 1'b1;
        n = 0;
        prev = 0;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            step();
            if (request_valid_out) begin
                exp_g = rr_pick(4'hF, m_last);
                m_last = exp_g;
                checks++;
                if (grant_index_out !== 2'(exp_g)) begin
                    errors++; $display("FAIL fair_order got %0d want %0d", grant_index_out, exp_g);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - prev != 3) begin
                        errors++; $display("FAIL fair_spacing got %0d want 3", cyc - prev);
                    end
                end
                prev = cyc;
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL fair_count got %0d want 8", n);
        end
        valid = '0;
        step(); step(); step();
        ack_in = 1'b0;
    endtask

    task automatic test_stall();
        int acks;
        do_reset();
        data[1] = 64'h1111_2222_3333_4444;
        data[3] = 64'h5555_6666_7777_8888;
        valid = 4'b1010;
        step();
        checks++;
        if (request_valid_out !== 1'b1 || grant_index_out !== 2'd1 || request_out !== data[1]) begin
            errors++;
            $display("FAIL stall_first got v=%b g=%0d d=%h want v=1 g=1 d=%h",
                     request_valid_out, grant_index_out, request_out, data[1]);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (busy_out !== 1'b1 || request_valid_out !== 1'b1 || request_out !== data[1] ||
                grant_index_out !== 2'd1 || issue_ack_packed_out !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got busy=%b v=%b d=%h g=%0d ack=%b", c,
                         busy_out, request_valid_out, request_out, grant_index_out, issue_ack_packed_out);
            end
        end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        checks++;
        if (issue_ack_packed_out !== 4'b0010) begin
            errors++; $display("FAIL stall_ack got %b want 0010", issue_ack_packed_out);
        end
        acks = $countones(issue_ack_packed_out);
        valid[1] = 1'b0;
        step();
        acks += $countones(issue_ack_packed_out);
        checks++;
        if (acks != 1) begin
            errors++; $display("FAIL stall_ack_count got %0d want 1", acks);
        end
    endtask

    task automatic test_mask();
        int n;
        int exp_g;
        do_reset();
        valid = '1;
        mask = 4'b1010;
        ack_in = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            step();
            if (request_valid_out) begin
                exp_g = rr_pick(valid & mask, m_last);
                m_last = exp_g;
                checks++;
                if (grant_index_out !== 2'(exp_g)) begin
                    errors++; $display("FAIL mask_order got %0d want %0d", grant_index_out, exp_g);
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin
            errors++; $display("FAIL mask_count got %0d want 6", n);
        end
        do_reset();
        valid = '1;
        mask = 4'b0010;
        step();
        mask = 4'b1000;
        step();
        checks++;
        if (request_valid_out !== 1'b1 || grant_index_out !== 2'd1) begin
            errors++; $display("FAIL mask_keep got v=%b g=%0d want v=1 g=1", request_valid_out, grant_index_out);
        end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        checks++;
        if (issue_ack_packed_out !== 4'b0010) begin
            errors++; $display("FAIL mask_drop_ack got %b want 0010", issue_ack_packed_out);
        end
        step();
        step();
        checks++;
        if (request_valid_out !== 1'b1 || grant_index_out !== 2'd3) begin
            errors++; $display("FAIL mask_next got v=%b g=%0d want v=1 g=3", request_valid_out, grant_index_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data[2] = 64'hDEAD_BEEF;
        valid = 4'b0100;
        step();
        step();
        #3 reset_in = 1'b0;
        #1;
        checks++;
        if ({busy_out, request_valid_out, issue_ack_packed_out, grant_index_out} !== 8'h00 ||
            request_out !== '0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b v=%b ack=%b g=%0d d=%h want all 0",
                     busy_out, request_valid_out, issue_ack_packed_out, grant_index_out, request_out);
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        m_last = N - 1;
        valid = '1;
        step();
        checks++;
        if (request_valid_out !== 1'b1 || grant_index_out !== 2'd0) begin
            errors++; $display("FAIL reset_mid_next got v=%b g=%0d want v=1 g=0", request_valid_out, grant_index_out);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        ack_in = 1'b1;
        step();
        checks++;
        if (busy_out !== 1'b0 || issue_ack_packed_out !== 4'b0000 || request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL spur_idle got busy=%b ack=%b v=%b want 0", busy_out, issue_ack_packed_out, request_valid_out);
        end
        ack_in = 1'b0;
        valid = 4'b0001;
        step();
        ack_in = 1'b1;
        step();
        checks++;
        if (issue_ack_packed_out !== 4'b0001) begin
            errors++; $display("FAIL spur_real_ack got %b want 0001", issue_ack_packed_out);
        end
        valid = '0;
        step();
        checks++;
        if (busy_out !== 1'b0 || issue_ack_packed_out !== 4'b0000 || request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL spur_ack got busy=%b ack=%b v=%b want 0", busy_out, issue_ack_packed_out, request_valid_out);
        end
        ack_in = 1'b0;
    endtask

    task automatic test_random(input int cycles);
        int phase;
        int g;
        int w;
        logic [W-1:0] exp_data;
        logic         exp_valid;
        logic [N-1:0] exp_ack;
        do_reset();
        phase = 0;
        g = 0;
        exp_data = '0;
        exp_valid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && $urandom_range(2) == 0) begin
                    valid[i] = 1'b1;
                    data[i] = {$urandom, $urandom};
                end
            end
            if ($urandom_range(3) == 0) mask = 4'($urandom);
            ack_in = ($urandom_range(1) == 1);
            exp_ack = '0;
            case (phase)
                0: begin
                    w = rr_pick(valid & mask, m_last);
                    if (w >= 0) begin
                        g = w; exp_valid = 1'b1; exp_data = data[w]; phase = 1;
                    end else begin
                        exp_valid = 1'b0; exp_data = '0;
                    end
                end
                1: if (ack_in) begin
                    exp_valid = 1'b0; exp_data = '0; exp_ack = 4'b0001 << g; m_last = g; phase = 2;
                end
                default: phase = 0;
            endcase
            step();
            checks++;
            if (request_valid_out !== exp_valid || request_out !== exp_data) begin
                errors++;
                $display("FAIL rand_req cyc %0d got v=%b d=%h want v=%b d=%h", c,
                         request_valid_out, request_out, exp_valid, exp_data);
            end
            checks++;
            if (issue_ack_packed_out !== exp_ack || busy_out !== (phase != 0)) begin
                errors++;
                $display("FAIL rand_ack cyc %0d got ack=%b busy=%b want ack=%b busy=%b", c,
                         issue_ack_packed_out, busy_out, exp_ack, (phase != 0));
            end
            if (phase == 1) begin
                checks++;
                if (grant_index_out !== 2'(g)) begin
                    errors++; $display("FAIL rand_grant cyc %0d got %0d want %0d", c, grant_index_out, g);
                end
            end
            if (exp_ack != '0) begin
                valid[g] = 1'($urandom_range(1));
                data[g] = {$urandom, $urandom};
            end
        end
        valid = '0;
        ack_in = 1'b0;
    endtask

    initial begin
        reset_in = 1'b0;
        valid = '0;
        mask = '1;
        ack_in = 1'b0;
        for (int i = 0; i < N; i++) data[i] = '0;
        m_last = N - 1;
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_mask();
        test_reset_mid();
        test_spurious();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
